simul_axi_wburst_gen: RTL

Simulation-only write-burst generator that sits directly upstream of the AXI master write-data channel model. It accepts one burst command at a time (ID, length, start data, increment, strobe), expands it into individual beats, and pushes them into the write-data FIFO through its `set_cmd`/`ready` load handshake. It marks the final beat with `wlast_in`. Testbenches issue whole bursts instead of driving beats one by one.

---
 rtl/simul_axi_pkg.sv | 14 +
 rtl/simul_axi_wburst_gen_if.sv | 39 +++
 rtl/simul_axi_wburst_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/simul_axi_pkg.sv
// Shared widths and state encoding for the simulation AXI channel models.
package simul_axi_pkg;

    localparam int AXI3_LEN_WIDTH = 4;
    localparam int DEF_ID_WIDTH   = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_WSTB_WIDTH = DEF_DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wburst_state_t;

endpackage

// File: rtl/simul_axi_wburst_gen_if.sv
// Command and beat signals between the burst generator and its neighbours.
interface simul_axi_wburst_gen_if
    import simul_axi_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WSTB_WIDTH = DEF_WSTB_WIDTH,
    parameter int LEN_WIDTH  = AXI3_LEN_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] cmd_incr;
    logic [WSTB_WIDTH-1:0] cmd_strb;

    logic [ID_WIDTH-1:0]   wid_in;
    logic [DATA_WIDTH-1:0] wdata_in;
    logic [WSTB_WIDTH-1:0] wstrb_in;
    logic                  wlast_in;
    logic                  set_cmd;
    logic                  ready;

    logic                  busy;
    logic                  burst_done;

    modport master (
        input  cmd_valid, cmd_id, cmd_len, cmd_data, cmd_incr, cmd_strb, ready,
        output cmd_ready, wid_in, wdata_in, wstrb_in, wlast_in, set_cmd, busy, burst_done
    );

    modport slave (
        output cmd_valid, cmd_id, cmd_len, cmd_data, cmd_incr, cmd_strb, ready,
        input  cmd_ready, wid_in, wdata_in, wstrb_in, wlast_in, set_cmd, busy, burst_done
    );

endinterface

// File: rtl/simul_axi_wburst_gen.sv
// Expands one burst command into len+1 write beats, one per cycle while the FIFO is ready.
// A new command may be taken on the last-beat edge so bursts run back to back.
module simul_axi_wburst_gen
    import simul_axi_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WSTB_WIDTH = DEF_WSTB_WIDTH,
    parameter int LEN_WIDTH  = AXI3_LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    simul_axi_wburst_gen_if.master bus
);

    wburst_state_t         state;
    wburst_state_t         state_nxt;

    logic [ID_WIDTH-1:0]   id_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] incr_q;
    logic [WSTB_WIDTH-1:0] strb_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  done_q;

    logic                  in_burst;
    logic                  last_beat;
    logic                  xfer;
    logic                  can_take;
    logic                  accept;

    // can_take is kept free of reset so the async reset never feeds flop D inputs
    always_comb begin
        in_burst  = (state == ST_BURST);
        last_beat = in_burst && (cnt_q == len_q);
        xfer      = in_burst && bus.ready;
        can_take  = !in_burst || (last_beat && bus.ready);
        accept    = bus.cmd_valid && can_take;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_BURST;
            ST_BURST: if (xfer && last_beat && !accept) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready  = reset && can_take;
        bus.set_cmd    = xfer;
        bus.wid_in     = id_q;
        bus.wdata_in   = data_q;
        bus.wstrb_in   = strb_q;
        bus.wlast_in   = last_beat;
        bus.busy       = in_burst;
        bus.burst_done = done_q;
    end

    // A command accepted on the last-beat edge overrides the beat advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q   <= '0;
            len_q  <= '0;
            data_q <= '0;
            incr_q <= '0;
            strb_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last_beat;
            if (accept) begin
                id_q   <= bus.cmd_id;
                len_q  <= bus.cmd_len;
                data_q <= bus.cmd_data;
                incr_q <= bus.cmd_incr;
                strb_q <= bus.cmd_strb;
                cnt_q  <= '0;
            end else if (xfer) begin
                cnt_q  <= cnt_q + LEN_WIDTH'(1);
                data_q <= data_q + incr_q;
            end
        end
    end

endmodule
